// File: rtl/dmac_src_fifo_pack_inf_pkg.sv
// Shared definitions for the DMAC free-running source interface.
// Holds the default configuration constants and the pointer/level width helper.
package dmac_src_fifo_pack_inf_pkg;

  localparam int unsigned C_ID_WIDTH_DEF     = 3;
  localparam int unsigned C_DATA_WIDTH_DEF   = 64;
  localparam int unsigned C_IN_WIDTH_DEF     = 16;
  localparam int unsigned C_FIFO_DEPTH_DEF   = 4;
  localparam int unsigned C_LENGTH_WIDTH_DEF = 24;

  // Index width for a power-of-two count; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmac_data_mover.sv
// Burst data mover between the word FIFO and the DMA datapath.
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   enable / enabled            channel enable in, enabled status out
//   sync_id, request_id         resynchronise response_id to request_id
//   response_id                 ID of the last completed burst
//   eot, req_*                  burst request handshake and last-burst length
//   s_axi_*                     word input (from FIFO head)
//   m_axi_*                     registered word output (to fifo_* side)
module dmac_data_mover #(
  parameter int unsigned ID_W                = 3,
  parameter int unsigned DATA_W              = 64,
  parameter bit          DISABLE_WAIT_FOR_ID = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  output logic              enabled,
  input  logic              sync_id,
  input  logic [ID_W-1:0]   request_id,
  output logic [ID_W-1:0]   response_id,
  input  logic              eot,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_last_burst_length,
  input  logic              s_axi_valid,
  output logic              s_axi_ready,
  input  logic [DATA_W-1:0] s_axi_data,
  output logic              m_axi_valid,
  input  logic              m_axi_ready,
  output logic [DATA_W-1:0] m_axi_data
);

  typedef enum logic [0:0] {ST_IDLE, ST_BURST} state_t;

  state_t state, state_nxt;
  logic [3:0] beat_cnt;
  logic [3:0] last_beat;
  logic       beat;
  logic       burst_done;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state and handshakes; when disabled the input is drained and discarded
  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    s_axi_ready = ~enable;
    beat        = 1'b0;
    burst_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = enable;
        if (req_valid && enable) state_nxt = ST_BURST;
      end
      ST_BURST: begin
        s_axi_ready = ~enable | m_axi_ready;
        beat        = enable & m_axi_ready & s_axi_valid;
        if (!enable) begin
          state_nxt  = ST_IDLE;
          burst_done = 1'b1;
        end else if (beat && (beat_cnt == last_beat)) begin
          state_nxt  = ST_IDLE;
          burst_done = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Beat counting, output register, response ID and enabled status
  always_ff @(posedge clk) begin
    if (!resetn) begin
      beat_cnt    <= '0;
      last_beat   <= '0;
      m_axi_valid <= 1'b0;
      m_axi_data  <= '0;
      response_id <= '0;
      enabled     <= 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        beat_cnt  <= '0;
        last_beat <= eot ? req_last_burst_length : 4'hF;
      end else if (beat) begin
        beat_cnt <= beat_cnt + 4'd1;
      end

      if (beat) begin
        m_axi_valid <= 1'b1;
        m_axi_data  <= s_axi_data;
      end else if (m_axi_ready) begin
        m_axi_valid <= 1'b0;
      end

      if (sync_id)         response_id <= request_id;
      else if (burst_done) response_id <= response_id + ID_W'(1);

      // Without the ID wait option, stay enabled until the burst and output drain
      if (enable) enabled <= 1'b1;
      else if (DISABLE_WAIT_FOR_ID || ((state == ST_IDLE) && !m_axi_valid)) enabled <= 1'b0;
    end
  end

endmodule

// File: rtl/dmac_src_fifo_pack_inf.sv
// DMAC source interface for free-running (non-back-pressurable) sources.
// Packs C_IN_WIDTH samples little-endian into C_DATA_WIDTH words, buffers them
// in a C_FIFO_DEPTH-entry FIFO and hands them to the data mover.
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   enable/enabled, sync_id/_ret     channel control, passed to/from the mover
//   request_id/response_id, eot      request bookkeeping
//   en, din, sync                    sample strobe, sample data, user sync strobe
//   overflow, overflow_count         lost-sample pulse and saturating count
//   fifo_level                       words held in the FIFO
//   fifo_valid/ready/data            downstream word stream
//   req_*                            burst request handshake, user-sync arm
module dmac_src_fifo_pack_inf
  import dmac_src_fifo_pack_inf_pkg::*;
#(
  parameter int unsigned C_ID_WIDTH     = C_ID_WIDTH_DEF,
  parameter int unsigned C_DATA_WIDTH   = C_DATA_WIDTH_DEF,
  parameter int unsigned C_IN_WIDTH     = C_IN_WIDTH_DEF,
  parameter int unsigned C_FIFO_DEPTH   = C_FIFO_DEPTH_DEF,
  parameter int unsigned C_LENGTH_WIDTH = C_LENGTH_WIDTH_DEF
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              enable,
  output logic                              enabled,
  input  logic                              sync_id,
  output logic                              sync_id_ret,
  input  logic [C_ID_WIDTH-1:0]             request_id,
  output logic [C_ID_WIDTH-1:0]             response_id,
  input  logic                              eot,
  input  logic                              en,
  input  logic [C_IN_WIDTH-1:0]             din,
  input  logic                              sync,
  output logic                              overflow,
  output logic [15:0]                       overflow_count,
  output logic [ptr_width(C_FIFO_DEPTH):0]  fifo_level,
  input  logic                              fifo_ready,
  output logic                              fifo_valid,
  output logic [C_DATA_WIDTH-1:0]           fifo_data,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [3:0]                        req_last_burst_length,
  input  logic                              req_sync_on_user
);

  localparam int unsigned R  = C_DATA_WIDTH / C_IN_WIDTH;
  localparam int unsigned CW = ptr_width(R);
  localparam int unsigned PW = ptr_width(C_FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;

  // Reject configurations the packer and FIFO cannot represent
  if ((R < 1) || ((R & (R - 1)) != 0) || (C_FIFO_DEPTH < 2) ||
      ((C_FIFO_DEPTH & (C_FIFO_DEPTH - 1)) != 0) || (C_LENGTH_WIDTH < 1)) begin : g_bad_cfg
    $error("dmac_src_fifo_pack_inf: unsupported parameter set");
  end

  logic [CW-1:0]           cnt;
  logic                    sync_armed;
  logic [C_DATA_WIDTH-1:0] pack;
  logic [C_DATA_WIDTH-1:0] pack_w;
  logic [C_DATA_WIDTH-1:0] mem [C_FIFO_DEPTH];
  logic [LW-1:0]           wr_ptr;
  logic [LW-1:0]           rd_ptr;
  logic [LW-1:0]           level;
  logic                    s_valid;
  logic                    s_ready;
  logic                    arm;
  logic                    accept;
  logic                    last_lane;
  logic                    full;
  logic                    pop;
  logic                    push;
  logic                    drop_word;
  logic                    drop_dis;

  assign sync_id_ret = sync_id;

  // Arming takes priority over any sample in the same cycle
  assign arm       = req_valid & req_ready & req_sync_on_user;
  assign accept    = en & enable & ~arm & (~sync_armed | sync);
  assign last_lane = (cnt == CW'(R - 1));

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == LW'(C_FIFO_DEPTH));
  assign s_valid = (level != '0);
  assign pop     = s_ready & s_valid;
  assign push    = accept & last_lane & (~full | pop);

  assign drop_word = accept & last_lane & full & ~pop;
  assign drop_dis  = en & ~enable;

  assign fifo_level = level;

  // Pack register with the current sample merged into its lane
  always_comb begin
    pack_w = pack;
    for (int unsigned l = 0; l < R; l++) begin
      if (cnt == CW'(l)) pack_w[l*C_IN_WIDTH +: C_IN_WIDTH] = din;
    end
  end

  // Lane counter, pack register and user-sync arming
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt        <= '0;
      sync_armed <= 1'b0;
      pack       <= '0;
    end else if (!enable) begin
      cnt        <= '0;
      sync_armed <= 1'b0;
    end else if (arm) begin
      cnt        <= '0;
      sync_armed <= 1'b1;
    end else if (accept) begin
      cnt        <= last_lane ? '0 : cnt + CW'(1);
      sync_armed <= 1'b0;
      pack       <= pack_w;
    end
  end

  // FIFO pointers carry an extra wrap bit so full and empty are distinct
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LW'(1);
      if (pop)  rd_ptr <= rd_ptr + LW'(1);
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= pack_w;
  end

  // Overflow pulse and saturating lost-sample count
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overflow       <= 1'b0;
      overflow_count <= '0;
    end else begin
      overflow <= drop_word | drop_dis;
      if ((drop_word || drop_dis) && (overflow_count != 16'hFFFF))
        overflow_count <= overflow_count + 16'd1;
    end
  end

  dmac_data_mover #(
    .ID_W                (C_ID_WIDTH),
    .DATA_W              (C_DATA_WIDTH),
    .DISABLE_WAIT_FOR_ID (1'b0)
  ) u_mover (
    .clk                   (clk),
    .resetn                (resetn),
    .enable                (enable),
    .enabled               (enabled),
    .sync_id               (sync_id),
    .request_id            (request_id),
    .response_id           (response_id),
    .eot                   (eot),
    .req_valid             (req_valid),
    .req_ready             (req_ready),
    .req_last_burst_length (req_last_burst_length),
    .s_axi_valid           (s_valid),
    .s_axi_ready           (s_ready),
    .s_axi_data            (mem[rd_ptr[PW-1:0]]),
    .m_axi_valid           (fifo_valid),
    .m_axi_ready           (fifo_ready),
    .m_axi_data            (fifo_data)
  );

endmodule
